// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: SPI master for an LTC2308-style 12-bit serial ADC.
// Each start sweeps channels 0..NUM_CH-1: CONVST pulse, conversion wait,
// 12-bit SDO read with the next channel's config word shifted out on SDI.
// The ADC applies a config word to the following conversion, so frame 0's
// result is dropped and frame f (f>=1) yields channel f-1.
// Optional feature macro: ADC_MAXTRACK_EN adds max_sample/max_ch tracking.
`timescale 1ns/1ps

module adc_spi_sampler #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CONV_CYCLES = 80,
    parameter int unsigned NUM_CH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [11:0] sample,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        sweep_done
`ifdef ADC_MAXTRACK_EN
    ,
    output logic [11:0] max_sample,
    output logic [2:0]  max_ch
`endif
);

    localparam int unsigned CNT_MAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned F_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT,
        S_SHIFT,
        S_EMIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [F_W-1:0]   frame;
    logic [3:0]       bit_idx;
    logic [11:0]      shreg;

    logic [2:0]       cfg_ch;
    logic [5:0]       cfg;
    logic [3:0]       nxt_idx;
    logic             nxt_sdi;
    logic             half_end;
    logic             last_frame;
    logic             shift_done;

    // Config word of the current frame and per-bit helpers for the shifter
    always_comb begin
        cfg_ch     = (frame < F_W'(NUM_CH)) ? frame[2:0] : 3'd0;
        cfg        = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], 1'b1, 1'b0};
        nxt_idx    = bit_idx + 4'd1;
        nxt_sdi    = (nxt_idx < 4'd6) ? cfg[3'(4'd5 - nxt_idx)] : 1'b0;
        half_end   = (cnt == CNT_W'(CLK_DIV - 1));
        last_frame = (frame == F_W'(NUM_CH));
        shift_done = (state == S_SHIFT) && half_end && adc_sck && (bit_idx == 4'd11);
    end

    // Sweep FSM with registered ADC pins, strobes and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            frame        <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            busy         <= 1'b0;
            adc_convst   <= 1'b0;
            adc_sck      <= 1'b0;
            adc_sdi      <= 1'b0;
            sample       <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            sweep_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_CONV;
                        frame      <= '0;
                        cnt        <= '0;
                        adc_convst <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (cnt == CNT_W'(1)) begin
                        state      <= S_WAIT;
                        cnt        <= '0;
                        adc_convst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
                        state   <= S_SHIFT;
                        cnt     <= '0;
                        bit_idx <= '0;
                        adc_sdi <= cfg[5];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (!adc_sck) begin
                            adc_sck <= 1'b1;
                            shreg   <= {shreg[10:0], adc_sdo};
                        end else begin
                            adc_sck <= 1'b0;
                            if (bit_idx == 4'd11) begin
                                state   <= S_EMIT;
                                adc_sdi <= 1'b0;
                                if (frame != '0) begin
                                    sample       <= shreg;
                                    sample_ch    <= 3'(frame - F_W'(1));
                                    sample_valid <= 1'b1;
                                end
                                sweep_done <= last_frame;
                            end else begin
                                bit_idx <= nxt_idx;
                                adc_sdi <= nxt_sdi;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (last_frame) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= S_CONV;
                        frame      <= frame + F_W'(1);
                        cnt        <= '0;
                        adc_convst <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ADC_MAXTRACK_EN
    logic [11:0] run_max;
    logic [2:0]  run_ch;
    logic [11:0] cand_max;
    logic [2:0]  cand_ch;

    // Strictly-greater replacement keeps the lowest channel on ties
    always_comb begin
        cand_max = run_max;
        cand_ch  = run_ch;
        if (shreg > run_max) begin
            cand_max = shreg;
            cand_ch  = 3'(frame - F_W'(1));
        end
    end

    // Running max per sweep, published on the sweep_done cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_max    <= '0;
            run_ch     <= '0;
            max_sample <= '0;
            max_ch     <= '0;
        end else if (state == S_IDLE && start) begin
            run_max <= '0;
            run_ch  <= '0;
        end else if (shift_done && frame != '0) begin
            run_max <= cand_max;
            run_ch  <= cand_ch;
            if (last_frame) begin
                max_sample <= cand_max;
                max_ch     <= cand_ch;
            end
        end
    end
`endif

endmodule
